// File: rtl/pcm_meter.sv
// pcm_meter: audio level meter for the 16-bit signed PCM bus.
// A rectifier stage feeds an instant-attack / exponential-decay envelope,
// a held peak and a stretched clip flag. The registered 7-LED bargraph
// shows the envelope on a 6 dB-per-step log scale with a peak dot and clip LED.
module pcm_meter #(
    parameter int DECAY_DIV   = 65536,
    parameter int DECAY_SHIFT = 5,
    parameter int HOLD_TICKS  = 512,
    parameter int CLIP_TICKS  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pcm,
    input  logic        freeze,
    output logic [6:0]  led,
    output logic        clip,
    output logic [14:0] level,
    output logic [14:0] peak
);

    // Counter widths. Each is wide enough that its load value never wraps.
    localparam int TICK_W_RAW = $clog2(DECAY_DIV);
    localparam int TICK_W     = (TICK_W_RAW < 1) ? 1 : TICK_W_RAW;
    localparam int HOLD_W_RAW = $clog2(HOLD_TICKS + 1);
    localparam int HOLD_W     = (HOLD_W_RAW < 1) ? 1 : HOLD_W_RAW;
    localparam int CLIP_W_RAW = $clog2(CLIP_TICKS + 1);
    localparam int CLIP_W     = (CLIP_W_RAW < 1) ? 1 : CLIP_W_RAW;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DECAY_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
    localparam logic [CLIP_W-1:0] CLIP_LOAD = CLIP_W'(CLIP_TICKS);

    localparam logic [14:0] FULL_SCALE = 15'h7FFF;
    localparam logic [14:0] BASE_THRESH = 15'd512;

    // Pipeline and tracking state.
    logic [14:0]       r_mag;
    logic [14:0]       r_env;
    logic [14:0]       r_pk;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [CLIP_W-1:0] r_clipCnt;
    logic              r_clip;
    logic [TICK_W-1:0] r_tickCnt;
    logic [6:0]        r_led;

    // Combinational helpers.
    logic [14:0] w_negMag;
    logic [14:0] w_mag;
    logic        w_tick;
    logic [14:0] w_decayAmt;
    logic [14:0] w_envDecayed;
    logic [5:0]  w_therm;
    logic [5:0]  w_dot;

    // Full-wave rectifier. The low 15 bits of the two's-complement negation
    // give the magnitude for every negative code except 0x8000, whose true
    // magnitude 32768 does not fit and is pinned to full scale instead.
    always_comb begin
        w_negMag = (~pcm[14:0]) + 15'd1;
        w_mag    = pcm[14:0];
        if (pcm == 16'h8000) begin
            w_mag = FULL_SCALE;
        end else if (pcm[15]) begin
            w_mag = w_negMag;
        end
    end

    // Stage 1: register the rectified magnitude.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag <= '0;
        end else begin
            r_mag <= w_mag;
        end
    end

    // Free-running decay timebase; the tick is the last count before wrap.
    assign w_tick = (r_tickCnt == TICK_LAST);

    // Decay tick counter, independent of input activity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tickCnt <= '0;
        end else if (w_tick) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TICK_W'(1);
        end
    end

    // One decay step of the envelope. When the proportional step rounds to
    // zero the envelope still creeps down by one so it always reaches zero,
    // and it never steps below zero.
    always_comb begin
        w_decayAmt   = r_env >> DECAY_SHIFT;
        w_envDecayed = r_env;
        if (w_decayAmt != 15'd0) begin
            w_envDecayed = r_env - w_decayAmt;
        end else if (r_env != 15'd0) begin
            w_envDecayed = r_env - 15'd1;
        end
    end

    // Envelope: attack always beats a coincident decay tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_env <= '0;
        end else if (r_mag > r_env) begin
            r_env <= r_mag;
        end else if (w_tick) begin
            r_env <= w_envDecayed;
        end
    end

    // Peak hold: a new peak (or a repeat of the current one) restarts the
    // hold time; once the hold expires the peak falls back to the envelope
    // on each tick. A silent input never counts as reaching the peak.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pk      <= '0;
            r_holdCnt <= '0;
        end else if ((r_mag >= r_pk) && (r_mag != 15'd0)) begin
            r_pk      <= r_mag;
            r_holdCnt <= HOLD_LOAD;
        end else if (w_tick) begin
            if (r_holdCnt != '0) begin
                r_holdCnt <= r_holdCnt - HOLD_W'(1);
            end else begin
                r_pk <= r_env;
            end
        end
    end

    // Clip stretcher: a full-scale sample relights the flag and restarts the
    // stretch, taking priority over a decrement on the same tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clip    <= 1'b0;
            r_clipCnt <= '0;
        end else if (r_mag == FULL_SCALE) begin
            r_clip    <= 1'b1;
            r_clipCnt <= CLIP_LOAD;
        end else if (w_tick) begin
            if (r_clipCnt != '0) begin
                r_clipCnt <= r_clipCnt - CLIP_W'(1);
            end else begin
                r_clip <= 1'b0;
            end
        end
    end

    // Thermometer: one LED per 6 dB step starting at 512.
    always_comb begin
        w_therm = '0;
        for (int k = 0; k < 6; k++) begin
            w_therm[k] = (r_env >= (BASE_THRESH << k));
        end
    end

    // Peak dot: one-hot at the highest step the held peak reaches; later
    // loop iterations overwrite earlier ones so the highest step wins.
    always_comb begin
        w_dot = '0;
        for (int k = 0; k < 6; k++) begin
            if (r_pk >= (BASE_THRESH << k)) begin
                w_dot = 6'b000001 << k;
            end
        end
    end

    // LED register: frozen display holds, otherwise reloads every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else if (!freeze) begin
            r_led <= {r_clip, w_therm | w_dot};
        end
    end

    assign led   = r_led;
    assign clip  = r_clip;
    assign level = r_env;
    assign peak  = r_pk;

endmodule

// File: tb/tb_pcm_meter.sv
// tb_pcm_meter: directed-vector bench for pcm_meter using a short decay
// timebase (tick every 4 clocks, shift 2, hold 3 ticks, clip stretch 2 ticks).
// Every scenario starts from reset so the tick phase is known: counting
// edges after reset release as E1, E2, ..., decay ticks land on E4, E8, E12...
module tb_pcm_meter;

   logic        clk;
   logic        rst;
   logic [15:0] pcm;
   logic        freeze;
   logic [6:0]  led;
   logic        clip;
   logic [14:0] level;
   logic [14:0] peak;

   int checkCount;
   int errorCount;
   int edgeNum;

   pcm_meter #(
      .DECAY_DIV  (4),
      .DECAY_SHIFT(2),
      .HOLD_TICKS (3),
      .CLIP_TICKS (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .pcm   (pcm),
      .freeze(freeze),
      .led   (led),
      .clip  (clip),
      .level (level),
      .peak  (peak)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input int got, input int exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive the sample and freeze inputs.
   task automatic applyStimulus(input logic [15:0] p, input logic f);
      pcm    = p;
      freeze = f;
   endtask

   // Advance one rising edge and settle 1 ns past it.
   task automatic stepClock();
      @(posedge clk);
      #1;
      edgeNum++;
   endtask

   // Advance until edge number e after reset release has just passed.
   task automatic runTo(input int e);
      while (edgeNum < e) stepClock();
   endtask

   // Reset with quiet inputs; released 1 ns after an edge so E1 is next.
   task automatic resetDut();
      applyStimulus(16'h0000, 1'b0);
      rst = 1'b1;
      stepClock();
      rst = 1'b0;
      edgeNum = 0;
   endtask

   // Directed scenarios.
   initial begin
      checkCount = 0;
      errorCount = 0;
      edgeNum    = 0;
      rst        = 1'b0;
      applyStimulus(16'h0000, 1'b0);
      #1 rst = 1'b1;
      #2;
      checkOutput("reset level", int'(level), 0);
      checkOutput("reset peak", int'(peak), 0);
      checkOutput("reset clip", int'(clip), 0);
      checkOutput("reset led", int'(led), 0);
      stepClock();
      rst = 1'b0;
      edgeNum = 0;

      // Small input: -512 lights only the bottom LED, then 511 sits below it.
      resetDut();
      applyStimulus(16'hFE00, 1'b0);
      runTo(2);
      checkOutput("small level", int'(level), 512);
      checkOutput("small peak", int'(peak), 512);
      runTo(3);
      checkOutput("small led", int'(led), 7'b0000001);
      applyStimulus(16'h01FF, 1'b0);
      runTo(4);
      checkOutput("small first decay", int'(level), 384);
      runTo(41);
      checkOutput("sub-threshold led", int'(led), 0);
      checkOutput("sub-threshold level", int'(level), 511);
      checkOutput("sub-threshold peak", int'(peak), 511);

      // Step: one sample of 0x4000 then silence; peak dot holds led[5].
      resetDut();
      applyStimulus(16'h4000, 1'b0);
      runTo(1);
      applyStimulus(16'h0000, 1'b0);
      runTo(2);
      checkOutput("step level", int'(level), 16384);
      runTo(3);
      checkOutput("step led", int'(led), 7'b0111111);
      runTo(4);
      checkOutput("step tick1 level", int'(level), 12288);
      runTo(5);
      checkOutput("step tick1 led", int'(led), 7'b0111111);
      runTo(15);
      checkOutput("step peak held", int'(peak), 16384);
      runTo(16);
      checkOutput("step peak falls", int'(peak), 6912);
      checkOutput("step tick4 level", int'(level), 5184);
      runTo(17);
      checkOutput("step led after fall", int'(led), 7'b0001111);

      // Negative full scale: clip lights and stretches for two ticks.
      resetDut();
      applyStimulus(16'h8000, 1'b0);
      runTo(1);
      applyStimulus(16'h0000, 1'b0);
      runTo(2);
      checkOutput("clip set", int'(clip), 1);
      checkOutput("clip level", int'(level), 32767);
      runTo(3);
      checkOutput("clip led", int'(led), 7'b1111111);
      runTo(11);
      checkOutput("clip stretched", int'(clip), 1);
      runTo(12);
      checkOutput("clip cleared", int'(clip), 0);
      runTo(13);
      checkOutput("clip led after clear", int'(led), 7'b0111111);

      // Decay floor: 3 -> 2 -> 1 -> 0 and no underflow.
      resetDut();
      applyStimulus(16'h0003, 1'b0);
      runTo(1);
      applyStimulus(16'h0000, 1'b0);
      runTo(2);
      checkOutput("floor start", int'(level), 3);
      runTo(4);
      checkOutput("floor tick1", int'(level), 2);
      runTo(8);
      checkOutput("floor tick2", int'(level), 1);
      runTo(12);
      checkOutput("floor tick3", int'(level), 0);
      runTo(20);
      checkOutput("floor no underflow", int'(level), 0);

      // Freeze holds the bargraph while the envelope keeps tracking.
      resetDut();
      applyStimulus(16'h4000, 1'b1);
      runTo(3);
      checkOutput("freeze level", int'(level), 16384);
      checkOutput("freeze led held", int'(led), 0);
      applyStimulus(16'h4000, 1'b0);
      runTo(4);
      checkOutput("unfreeze led", int'(led), 7'b0111111);

      // Asynchronous reset while lit and clipping, away from any clock edge.
      resetDut();
      applyStimulus(16'h8001, 1'b0);
      runTo(1);
      applyStimulus(16'h0000, 1'b0);
      runTo(3);
      checkOutput("pre-reset clip", int'(clip), 1);
      checkOutput("pre-reset led", int'(led), 7'b1111111);
      #2 rst = 1'b1;
      #1;
      checkOutput("async level", int'(level), 0);
      checkOutput("async peak", int'(peak), 0);
      checkOutput("async clip", int'(clip), 0);
      checkOutput("async led", int'(led), 0);
      stepClock();
      rst = 1'b0;
      edgeNum = 0;
      runTo(10);
      checkOutput("post-reset level", int'(level), 0);
      checkOutput("post-reset peak", int'(peak), 0);
      checkOutput("post-reset clip", int'(clip), 0);
      checkOutput("post-reset led", int'(led), 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/pcm_meter.md
# pcm_meter

Audio level meter on the synthesizer's 16-bit signed PCM bus, in parallel with the delta-sigma output stage. Full-wave rectifies each sample and tracks an instant-attack / exponential-decay envelope. Also tracks a held peak and a stretched clip flag, and drives the 7-LED board bargraph on a 6 dB-per-step log scale.

## Interface
- DECAY_DIV, 65536 — clk cycles per decay tick (≥2)
- DECAY_SHIFT, 5 — envelope decay per tick = env >> DECAY_SHIFT (1..14)
- HOLD_TICKS, 512 — decay ticks the peak is held before falling
- CLIP_TICKS, 256 — decay ticks the clip indicator stays lit after the last full-scale sample

Ports:
- clk  in  1  system clock; pcm sampled every rising edge
- rst  in  1  asynchronous, active-high reset
- pcm  in  16  signed two's-complement sample
- freeze  in  1  1 = hold led outputs; internal tracking continues
- led  out  7  led[5:0] level bargraph, led[6] clip
- clip  out  1  stretched clip flag (unfrozen copy of clip state)
- level  out  15  current envelope
- peak  out  15  held peak

## Operation
- Rectify: mag = pcm[15] ? -pcm : pcm, 15-bit unsigned. 0x8000 saturates to 32767. Registered (stage 1, mag_r).
- Decay tick: free-running counter 0..DECAY_DIV-1. tick=1 for the one cycle at DECAY_DIV-1, then wraps to 0.
- Envelope (env, 15 bit), priority order:
  1. mag_r > env → env = mag_r (attack always beats decay).
  2. Else on tick: d = env >> DECAY_SHIFT; env = env − d if d≠0, else env − 1 if env≠0. Never underflows.
  3. Else hold.
- Peak (pk) and hold counter (hc), priority order:
  1. mag_r ≥ pk and mag_r≠0 → pk = mag_r, hc = HOLD_TICKS.
  2. Else on tick: if hc≠0 then hc−1, else pk = env.
- Clip: mag_r == 32767 (pcm 0x7FFF, 0x8000, 0x8001) → clip = 1, cc = CLIP_TICKS.
  - Else on tick: cc≠0 → cc−1; cc == 0 → clip = 0.
  - A clip reload on a tick cycle wins over the decrement.
- Thresholds: T_k = 512 << k, k = 0..5, i.e. 512, 1024, 2048, 4096, 8192, 16384.
- Bargraph:
  - Thermometer bit k = (env ≥ T_k).
  - Peak dot = one-hot at the highest k with pk ≥ T_k; none if pk < 512.
  - led[5:0] = thermometer | dot; led[6] = clip.
- led is a register. While freeze=1 it keeps its value; on freeze=0 it reloads every cycle.
- Outputs level = env, peak = pk, clip come straight from registers, unaffected by freeze.

## Timing
- Reset: every register goes to 0 asynchronously — mag_r, env, pk, hc, cc, tick counter, clip, led. All outputs read 0 during and after reset until new samples arrive.
- Reset mid-decay or mid-hold discards all state with no residual glow.
- Latency, pcm stable before edge E0:
  - mag_r after E0
  - env / pk / clip after E1
  - led after E2
- Pipeline is fully streaming, one sample per cycle, no stalls or handshake.
- Decay rate is independent of input activity. A tick coinciding with an attack does not decay that cycle.
- Widths: all arithmetic is 15-bit unsigned; hc and cc are sized for HOLD_TICKS and CLIP_TICKS with no wrap.

## Test plan
All scenarios use DECAY_DIV=4, DECAY_SHIFT=2, HOLD_TICKS=3, CLIP_TICKS=2.
- Small input: pcm=0xFE00 (−512) held → led=7'b0000001 two edges after mag_r. Then pcm=0x01FF (511), decay to 0 → led=7'b0000000.
- Step: one cycle of pcm=0x4000, then 0 → level=16384 and led=7'b0111111 after E2. First tick: level=12288, led still 7'b0111111 because the peak dot holds led[5]. After 3 further ticks pk falls to env and led[5]=0.
- Negative full scale: pcm=0x8000 for one cycle → level=32767, clip=1, led[6]=1. clip stays 1 through two ticks and clears on the third tick after the sample.
- Decay floor: set level=3 with pcm=3, then pcm=0 → level goes 3→2→1→0 on successive ticks, then stays 0 (no underflow).
- Freeze: freeze=1, pcm=0x4000 → led stays 0 while level=16384. Release freeze → led=7'b0111111 one edge later.
- Async reset: rst pulse while level≠0, clip=1 → all outputs 0 immediately, without waiting for a clk edge. With pcm=0 after release, outputs remain 0.
